// File: rtl/gups_pkg.sv
// Shared types and defaults for the GUPS memory-port arbiter.
// Holds the FSM state encoding and the default address/data widths.
package gups_pkg;

    localparam int AW_DEF = 64;
    localparam int DW_DEF = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

endpackage

// File: rtl/gups_mem_arbiter_rr_pick.sv
// Round-robin picker: finds the first set request bit at or after ptr, wrapping modulo N.
// Purely combinational. Works for N values that are not powers of two.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] gnt_idx,
    output logic          any
);

    logic [PW:0] idx_s;

    // Scan from the farthest offset down to ptr itself so the nearest request wins
    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        idx_s   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx_s = {1'b0, ptr} + (PW+1)'(k);
            if (idx_s >= (PW+1)'(N)) begin
                idx_s = idx_s - (PW+1)'(N);
            end else begin
                idx_s = idx_s;
            end
            if (req[idx_s[PW-1:0]]) begin
                gnt_idx = idx_s[PW-1:0];
                any     = 1'b1;
            end else begin
                any     = any;
            end
        end
    end

endmodule

// File: rtl/gups_mem_arbiter.sv
// Round-robin arbiter sharing one req/wr/rdy memory port among N update engines.
// One transaction in flight at a time; completion and read data are returned to the winner.
module gups_mem_arbiter
    import gups_pkg::*;
#(
    parameter int N  = 4,
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    r_req,
    input  logic [N-1:0]    r_wr,
    input  logic [N*AW-1:0] r_addr,
    input  logic [N*DW-1:0] r_dout,
    output logic [DW-1:0]   r_din,
    output logic [N-1:0]    r_rdy,
    output logic            m_req,
    output logic            m_wr,
    output logic [AW-1:0]   m_addr,
    output logic [DW-1:0]   m_dout,
    input  logic [DW-1:0]   m_din,
    input  logic            m_rdy,
    output logic            busy,
    output logic [31:0]     xact_cnt
);

    localparam int PW = $clog2(N);

    state_e          state_q, state_d;
    logic [PW-1:0]   grant_q, grant_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic            m_req_q, m_req_d;
    logic            m_wr_q, m_wr_d;
    logic [AW-1:0]   m_addr_q, m_addr_d;
    logic [DW-1:0]   m_dout_q, m_dout_d;
    logic [DW-1:0]   r_din_q, r_din_d;
    logic [N-1:0]    r_rdy_q, r_rdy_d;
    logic            busy_q, busy_d;
    logic [31:0]     xact_cnt_q, xact_cnt_d;

    logic [PW-1:0]   pick_idx_s;
    logic            pick_any_s;

    rr_pick #(
        .N  (N),
        .PW (PW)
    ) u_pick (
        .req     (r_req),
        .ptr     (ptr_q),
        .gnt_idx (pick_idx_s),
        .any     (pick_any_s)
    );

    // Next-state logic: IDLE grants, ISSUE waits for m_rdy, RESP pulses r_rdy and advances ptr
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        m_req_d    = m_req_q;
        m_wr_d     = m_wr_q;
        m_addr_d   = m_addr_q;
        m_dout_d   = m_dout_q;
        r_din_d    = r_din_q;
        r_rdy_d    = '0;
        xact_cnt_d = xact_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any_s) begin
                    grant_d  = pick_idx_s;
                    m_req_d  = 1'b1;
                    m_wr_d   = r_wr[pick_idx_s];
                    m_addr_d = r_addr[int'(pick_idx_s)*AW +: AW];
                    m_dout_d = r_dout[int'(pick_idx_s)*DW +: DW];
                    state_d  = ST_ISSUE;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (m_rdy) begin
                    if (!m_wr_q) begin
                        r_din_d = m_din;
                    end else begin
                        r_din_d = r_din_q;
                    end
                    m_req_d          = 1'b0;
                    m_wr_d           = 1'b0;
                    r_rdy_d[grant_q] = 1'b1;
                    state_d          = ST_RESP;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_RESP: begin
                ptr_d      = (grant_q == PW'(N - 1)) ? '0 : grant_q + PW'(1);
                xact_cnt_d = xact_cnt_q + 32'd1;
                state_d    = ST_IDLE;
            end
            default: begin
                m_req_d = 1'b0;
                m_wr_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // All arbiter state, with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            ptr_q      <= '0;
            m_req_q    <= 1'b0;
            m_wr_q     <= 1'b0;
            m_addr_q   <= '0;
            m_dout_q   <= '0;
            r_din_q    <= '0;
            r_rdy_q    <= '0;
            busy_q     <= 1'b0;
            xact_cnt_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            m_req_q    <= m_req_d;
            m_wr_q     <= m_wr_d;
            m_addr_q   <= m_addr_d;
            m_dout_q   <= m_dout_d;
            r_din_q    <= r_din_d;
            r_rdy_q    <= r_rdy_d;
            busy_q     <= busy_d;
            xact_cnt_q <= xact_cnt_d;
        end
    end

    assign r_din    = r_din_q;
    assign r_rdy    = r_rdy_q;
    assign m_req    = m_req_q;
    assign m_wr     = m_wr_q;
    assign m_addr   = m_addr_q;
    assign m_dout   = m_dout_q;
    assign busy     = busy_q;
    assign xact_cnt = xact_cnt_q;

endmodule

// File: tb/tb_gups_mem_arbiter.sv
// Self-checking bench for gups_mem_arbiter: directed vector table, hand-written
// corner sequences, and a bounded random GUPS-style soak with a reference memory.
module tb_gups_mem_arbiter;

    localparam int N       = 4;
    localparam int AW      = 64;
    localparam int DW      = 64;
    localparam int NSOAK   = 2000;
    localparam int BUDGET  = 40000;

    logic            clk;
    logic            rst;
    logic [N-1:0]    r_req;
    logic [N-1:0]    r_wr;
    logic [N*AW-1:0] r_addr;
    logic [N*DW-1:0] r_dout;
    logic [DW-1:0]   r_din;
    logic [N-1:0]    r_rdy;
    logic            m_req;
    logic            m_wr;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_dout;
    logic [DW-1:0]   m_din;
    logic            m_rdy;
    logic            busy;
    logic [31:0]     xact_cnt;

    int checks = 0;
    int errors = 0;

    gups_mem_arbiter #(.N(N), .AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .r_req    (r_req),
        .r_wr     (r_wr),
        .r_addr   (r_addr),
        .r_dout   (r_dout),
        .r_din    (r_din),
        .r_rdy    (r_rdy),
        .m_req    (m_req),
        .m_wr     (m_wr),
        .m_addr   (m_addr),
        .m_dout   (m_dout),
        .m_din    (m_din),
        .m_rdy    (m_rdy),
        .busy     (busy),
        .xact_cnt (xact_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          eng;
        logic        wr;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        int          dly;
        logic [63:0] exp_din;
    } vec_t;

    vec_t vecs [5];

    logic [63:0] mem     [0:8191];
    logic [63:0] ref_mem [0:8191];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    // One isolated transaction from a table record, checking every phase
    task automatic run_vec(input vec_t v, input logic [31:0] cnt_before);
        logic [N-1:0] exp_rdy;
        int other;
        exp_rdy = '0;
        exp_rdy[v.eng] = 1'b1;
        other = (v.eng + 1) % N;
        r_wr[v.eng] = v.wr;
        r_addr[v.eng*AW +: AW] = v.addr;
        r_dout[v.eng*DW +: DW] = v.wdata;
        r_req[v.eng] = 1'b1;
        step();
        chk("vec_m_req", 64'(m_req), 64'd1);
        chk("vec_m_wr", 64'(m_wr), 64'(v.wr));
        chk("vec_m_addr", m_addr, v.addr);
        chk("vec_m_dout", m_dout, v.wdata);
        chk("vec_busy", 64'(busy), 64'd1);
        for (int d = 0; d < v.dly; d++) begin
            r_addr[other*AW +: AW] = {$urandom, $urandom};
            r_dout[other*DW +: DW] = {$urandom, $urandom};
            step();
            chk("vec_hold_req", 64'(m_req), 64'd1);
            chk("vec_hold_addr", m_addr, v.addr);
            chk("vec_hold_dout", m_dout, v.wdata);
            chk("vec_hold_rdy", 64'(r_rdy), 64'd0);
        end
        m_rdy = 1'b1;
        m_din = v.rdata;
        step();
        chk("vec_r_rdy", 64'(r_rdy), 64'(exp_rdy));
        chk("vec_r_din", r_din, v.exp_din);
        chk("vec_m_req_low", 64'(m_req), 64'd0);
        m_rdy = 1'b0;
        m_din = '0;
        r_req[v.eng] = 1'b0;
        step();
        chk("vec_r_rdy_end", 64'(r_rdy), 64'd0);
        chk("vec_busy_end", 64'(busy), 64'd0);
        chk("vec_xact_cnt", 64'(xact_cnt), 64'(cnt_before + 32'd1));
    endtask

    initial begin
        logic [N-1:0] exp_rdy;
        logic [N-1:0] just;
        bit           pend    [N];
        bit           opw     [N];
        logic [63:0]  opa     [N];
        logic [63:0]  opd     [N];
        int           waited  [N];
        logic [63:0]  rec_a, rec_d, rec_r;
        logic         rec_w;
        int           g, done, dly, cyc, maxwait;

        vecs[0] = '{2, 1'b0, 64'h1A0,  64'h0,    64'hDEAD_BEEF_0123_4567, 2, 64'hDEAD_BEEF_0123_4567};
        vecs[1] = '{3, 1'b1, 64'h1FFF, 64'h5,    64'h0BAD_0BAD_0BAD_0BAD, 3, 64'hDEAD_BEEF_0123_4567};
        vecs[2] = '{0, 1'b0, 64'h40,   64'h0,    64'h1111,                0, 64'h1111};
        vecs[3] = '{1, 1'b1, 64'h80,   64'hAAAA, 64'h2222,                1, 64'h1111};
        vecs[4] = '{1, 1'b0, 64'h88,   64'h0,    64'hFFFF_FFFF_FFFF_FFFF, 0, 64'hFFFF_FFFF_FFFF_FFFF};

        rst    = 1'b0;
        r_req  = 4'b1111;
        r_wr   = '0;
        r_addr = '0;
        r_dout = '0;
        m_din  = '0;
        m_rdy  = 1'b0;

        // Reset held with every engine requesting
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_m_req", 64'(m_req), 64'd0);
            chk("rst_r_rdy", 64'(r_rdy), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_xact_cnt", 64'(xact_cnt), 64'd0);
            chk("rst_m_addr", m_addr, 64'd0);
            chk("rst_r_din", r_din, 64'd0);
        end
        rst   = 1'b1;
        r_req = '0;

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i], 32'(i));
        end

        // All engines requesting from reset: strict 0,1,2,3 rotation
        do_reset();
        for (int i = 0; i < N; i++) begin
            r_addr[i*AW +: AW] = 64'(i * 256);
        end
        r_wr  = '0;
        r_req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("rr_m_req", 64'(m_req), 64'd1);
            chk("rr_grant", 64'(m_addr[11:8]), 64'(k % N));
            m_rdy = 1'b1;
            m_din = 64'(k);
            step();
            exp_rdy = '0;
            exp_rdy[k % N] = 1'b1;
            chk("rr_r_rdy", 64'(r_rdy), 64'(exp_rdy));
            m_rdy = 1'b0;
            r_req[k % N] = 1'b0;
            step();
            chk("rr_r_rdy_pulse", 64'(r_rdy), 64'd0);
            r_req[k % N] = 1'b1;
        end
        r_req = '0;
        chk("rr_xact_cnt", 64'(xact_cnt), 64'd8);

        // Stray m_rdy in IDLE
        m_rdy = 1'b1;
        step();
        chk("stray_idle_busy", 64'(busy), 64'd0);
        chk("stray_idle_rdy", 64'(r_rdy), 64'd0);
        chk("stray_idle_cnt", 64'(xact_cnt), 64'd8);
        m_rdy = 1'b0;

        // m_rdy held through RESP and into IDLE
        r_wr[0] = 1'b0;
        r_addr[0 +: AW] = 64'h10;
        r_req[0] = 1'b1;
        step();
        m_rdy = 1'b1;
        m_din = 64'h77;
        step();
        chk("stray_resp_rdy", 64'(r_rdy), 64'd1);
        chk("stray_resp_din", r_din, 64'h77);
        m_din = 64'h99;
        r_req[0] = 1'b0;
        step();
        chk("stray_resp_rdy_end", 64'(r_rdy), 64'd0);
        chk("stray_resp_busy", 64'(busy), 64'd0);
        chk("stray_resp_cnt", 64'(xact_cnt), 64'd9);
        chk("stray_resp_din_keep", r_din, 64'h77);
        step();
        chk("stray_idle2_busy", 64'(busy), 64'd0);
        chk("stray_idle2_cnt", 64'(xact_cnt), 64'd9);
        m_rdy = 1'b0;

        // Reset while a transaction is in ISSUE, then a late m_rdy
        r_addr[1*AW +: AW] = 64'h20;
        r_req[1] = 1'b1;
        step();
        chk("midrst_m_req_pre", 64'(m_req), 64'd1);
        rst = 1'b0;
        step();
        chk("midrst_m_req", 64'(m_req), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_cnt", 64'(xact_cnt), 64'd0);
        rst   = 1'b1;
        r_req = '0;
        m_rdy = 1'b1;
        step();
        chk("late_rdy_busy", 64'(busy), 64'd0);
        chk("late_rdy_r_rdy", 64'(r_rdy), 64'd0);
        chk("late_rdy_cnt", 64'(xact_cnt), 64'd0);
        m_rdy = 1'b0;

        // Random soak: memory model stores what the DUT issues, reference memory tracks engine intent
        for (int i = 0; i < 8192; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
        for (int i = 0; i < N; i++) begin
            pend[i]   = 1'b0;
            opw[i]    = 1'b0;
            opa[i]    = '0;
            opd[i]    = '0;
            waited[i] = 0;
        end
        rec_a = '0; rec_d = '0; rec_r = '0; rec_w = 1'b0;
        done = 0; dly = 0; cyc = 0; maxwait = 0;
        while (done < NSOAK && cyc < BUDGET) begin
            step();
            cyc++;
            just = '0;
            if (r_rdy != '0) begin
                chk("soak_onehot", 64'($onehot(r_rdy)), 64'd1);
                g = 0;
                for (int i = 0; i < N; i++) begin
                    if (r_rdy[i]) g = i;
                end
                chk("soak_pending", 64'(pend[g]), 64'd1);
                chk("soak_addr", rec_a, opa[g]);
                chk("soak_wr", 64'(rec_w), 64'(opw[g]));
                if (opw[g]) begin
                    chk("soak_wdata", rec_d, opd[g]);
                    ref_mem[opa[g][12:0]] = opd[g];
                end else begin
                    chk("soak_rdata", r_din, ref_mem[opa[g][12:0]]);
                end
                pend[g]  = 1'b0;
                r_req[g] = 1'b0;
                just[g]  = 1'b1;
                done++;
                for (int i = 0; i < N; i++) begin
                    if (pend[i]) begin
                        waited[i]++;
                        if (waited[i] > maxwait) maxwait = waited[i];
                    end
                end
            end
            if (m_rdy) begin
                m_rdy = 1'b0;
            end else if (m_req) begin
                if (dly > 0) begin
                    dly--;
                end else begin
                    rec_a = m_addr;
                    rec_w = m_wr;
                    rec_d = m_dout;
                    if (m_wr) begin
                        mem[m_addr[12:0]] = m_dout;
                    end else begin
                        m_din = mem[m_addr[12:0]];
                    end
                    rec_r = mem[m_addr[12:0]];
                    m_rdy = 1'b1;
                    dly   = $urandom_range(2, 0);
                end
            end
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && !just[i] && $urandom_range(3, 0) != 0) begin
                    opw[i] = 1'($urandom_range(1, 0));
                    opa[i] = 64'($urandom_range(8191, 0));
                    opd[i] = {$urandom, $urandom};
                    r_wr[i] = opw[i];
                    r_addr[i*AW +: AW] = opa[i];
                    r_dout[i*DW +: DW] = opd[i];
                    r_req[i]  = 1'b1;
                    pend[i]   = 1'b1;
                    waited[i] = 0;
                end
            end
        end
        r_req = '0;
        m_rdy = 1'b0;
        chk("soak_done", 64'(done), 64'(NSOAK));
        step();
        chk("soak_xact_cnt", 64'(xact_cnt), 64'(NSOAK));
        chk("soak_idle", 64'(busy), 64'd0);
        chk("soak_fairness", 64'(maxwait <= N), 64'd1);
        chk("soak_rd_seen", 64'(rec_r === rec_r), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
